// File: rtl/div_unit.sv
// div_unit: 32-bit iterative restoring divider for the EX stage.
// Produces {remainder, quotient} in result_o 32 cycles after acceptance
// (1 cycle for a zero divisor). Signed operations divide magnitudes and
// fix up the signs on the final iteration. cancel_i flushes at any time.
module div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic        cancel_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stall_req_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DIVZERO = 2'd1;
    localparam logic [1:0] ST_DIVON   = 2'd2;
    localparam logic [1:0] ST_END     = 2'd3;

    localparam logic [5:0] LAST_ITER  = 6'd31;

    // Two's-complement negation, kept in one place for all sign handling.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        neg32 = (~v) + 32'd1;
    endfunction

    // Magnitude of an operand: negate only for signed ops with bit 31 set.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        if (is_signed && v[31]) begin
            mag32 = neg32(v);
        end else begin
            mag32 = v;
        end
    endfunction

    logic [1:0]  state_r;
    logic [5:0]  cnt_r;
    logic [31:0] dividend_r;   // dividend bits shift out, quotient bits shift in
    logic [31:0] divisor_r;
    logic [31:0] rem_r;        // partial remainder
    logic        q_neg_r;
    logic        r_neg_r;

    logic [32:0] trial_s;
    logic [31:0] diff_s;
    logic        qbit_s;
    logic [31:0] rem_next_s;
    logic [31:0] quo_next_s;
    logic [31:0] final_q_s;
    logic [31:0] final_r_s;
    logic        accept_s;

    // One restoring-division step: shift, trial-subtract, restore or keep.
    always_comb begin
        trial_s = {rem_r, dividend_r[31]};
        diff_s  = trial_s[31:0] - divisor_r;
        // The true difference is non-negative exactly when trial >= divisor;
        // in that case it fits in 32 bits, so the wrapped low word is exact.
        if (trial_s >= {1'b0, divisor_r}) begin
            qbit_s     = 1'b1;
            rem_next_s = diff_s;
        end else begin
            qbit_s     = 1'b0;
            rem_next_s = trial_s[31:0];
        end
        quo_next_s = {dividend_r[30:0], qbit_s};
    end

    // Sign correction applied to the values produced by the last step.
    always_comb begin
        if (q_neg_r) begin
            final_q_s = neg32(quo_next_s);
        end else begin
            final_q_s = quo_next_s;
        end
        if (r_neg_r) begin
            final_r_s = neg32(rem_next_s);
        end else begin
            final_r_s = rem_next_s;
        end
    end

    // A new operation is taken only from IDLE and never alongside a flush.
    always_comb begin
        if ((state_r == ST_IDLE) && start_i && !cancel_i) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Divider state machine, operand capture, iteration and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 6'd0;
            dividend_r <= 32'd0;
            divisor_r  <= 32'd0;
            rem_r      <= 32'd0;
            q_neg_r    <= 1'b0;
            r_neg_r    <= 1'b0;
            result_o   <= 64'd0;
            ready_o    <= 1'b0;
        end else if (cancel_i) begin
            // Flush wins over acceptance and completion; nothing partial leaks.
            state_r  <= ST_IDLE;
            cnt_r    <= 6'd0;
            rem_r    <= 32'd0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    result_o <= 64'd0;
                    ready_o  <= 1'b0;
                    if (accept_s) begin
                        dividend_r <= mag32(opdata1_i, signed_i);
                        divisor_r  <= mag32(opdata2_i, signed_i);
                        rem_r      <= 32'd0;
                        cnt_r      <= 6'd0;
                        q_neg_r    <= signed_i & (opdata1_i[31] ^ opdata2_i[31]);
                        r_neg_r    <= signed_i & opdata1_i[31];
                        if (opdata2_i == 32'd0) begin
                            state_r <= ST_DIVZERO;
                        end else begin
                            state_r <= ST_DIVON;
                        end
                    end
                end
                ST_DIVZERO: begin
                    state_r  <= ST_END;
                    result_o <= 64'd0;
                    ready_o  <= 1'b1;
                end
                ST_DIVON: begin
                    dividend_r <= quo_next_s;
                    rem_r      <= rem_next_s;
                    if (cnt_r == LAST_ITER) begin
                        state_r  <= ST_END;
                        cnt_r    <= 6'd0;
                        result_o <= {final_r_s, final_q_s};
                        ready_o  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                ST_END: begin
                    // Hold the result until EX drops its request.
                    if (!start_i) begin
                        state_r  <= ST_IDLE;
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cnt_r    <= 6'd0;
                    result_o <= 64'd0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

    // Stall EX while a division is pending or about to be accepted.
    always_comb begin
        stall_req_o = 1'b0;
        if (!rst_n) begin
            stall_req_o = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:    stall_req_o = start_i & ~cancel_i;
                ST_DIVZERO: stall_req_o = 1'b1;
                ST_DIVON:   stall_req_o = 1'b1;
                ST_END:     stall_req_o = 1'b0;
                default:    stall_req_o = 1'b0;
            endcase
        end
    end

endmodule
